// File: rtl/mig_arb_pkg.sv
// Shared types and constants for the two-port MIG app-interface arbiter.
// Command encodings match the mig_7series app_cmd field.
package mig_arb_pkg;

   localparam logic [2:0] CMD_WRITE = 3'b000;
   localparam logic [2:0] CMD_READ  = 3'b001;

   typedef enum logic [1:0] {
      S_CALIB,
      S_ARB,
      S_CMD
   } state_t;

   typedef logic port_id_t;

endpackage

// File: rtl/mig_tag_fifo.sv
// Read-tag FIFO: remembers which port issued each outstanding read,
// in the order the MIG will return the data.
module mig_tag_fifo #(
   parameter int DEPTH = 16
) (
   input  logic clk,
   input  logic rst,
   input  logic push,
   input  logic pop,
   input  logic din,
   output logic dout,
   output logic full,
   output logic empty
);

   localparam int AW = $clog2(DEPTH);

   logic          mem [DEPTH];
   logic [AW-1:0] wptr;
   logic [AW-1:0] rptr;
   logic [AW:0]   cnt;
   logic          do_push;
   logic          do_pop;

   assign full    = (cnt == (AW+1)'(DEPTH));
   assign empty   = (cnt == '0);
   assign do_pop  = pop & ~empty;
   assign do_push = push & (~full | do_pop);
   assign dout    = mem[rptr];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wptr <= '0;
         rptr <= '0;
         cnt  <= '0;
      end else begin
         if (do_push) wptr <= wptr + 1'b1;
         if (do_pop)  rptr <= rptr + 1'b1;
         unique case ({do_push, do_pop})
            2'b10:   cnt <= cnt + 1'b1;
            2'b01:   cnt <= cnt - 1'b1;
            default: cnt <= cnt;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wptr] <= din;
   end

endmodule

// File: rtl/mig_app_arbiter.sv
// Round-robin arbiter sharing the MIG app interface between two clients,
// with in-order read data routed back by a tag FIFO.
module mig_app_arbiter
   import mig_arb_pkg::*;
#(
   parameter int ADDR_W    = 29,
   parameter int DATA_W    = 256,
   parameter int TAG_DEPTH = 16
) (
   input  logic                ui_clk,
   input  logic                ui_clk_sync_rst,
   input  logic                init_calib_complete,
   input  logic                rq0_valid,
   input  logic                rq0_cmd,
   input  logic [ADDR_W-1:0]   rq0_addr,
   input  logic [DATA_W-1:0]   rq0_wdata,
   output logic                rq0_ready,
   input  logic                rq1_valid,
   input  logic                rq1_cmd,
   input  logic [ADDR_W-1:0]   rq1_addr,
   input  logic [DATA_W-1:0]   rq1_wdata,
   output logic                rq1_ready,
   output logic [DATA_W-1:0]   rd0_data,
   output logic                rd0_valid,
   output logic [DATA_W-1:0]   rd1_data,
   output logic                rd1_valid,
   output logic                app_en,
   output logic [2:0]          app_cmd,
   output logic [ADDR_W-1:0]   app_addr,
   output logic [DATA_W-1:0]   app_wdf_data,
   output logic                app_wdf_wren,
   output logic                app_wdf_end,
   output logic [DATA_W/8-1:0] app_wdf_mask,
   input  logic                app_rdy,
   input  logic                app_wdf_rdy,
   input  logic [DATA_W-1:0]   app_rd_data,
   input  logic                app_rd_data_valid,
   output logic                tag_err
);

   state_t   state;
   port_id_t ptr;
   port_id_t cur_port;
   port_id_t win;
   port_id_t tag_head;
   logic     cmd_done;
   logic     dat_done;
   logic     full;
   logic     empty;
   logic     elig0;
   logic     elig1;
   logic     gnt;
   logic     win_rd;
   logic     cmd_ok;
   logic     dat_ok;
   logic     c_nxt;
   logic     d_nxt;
   logic     push;
   logic     pop;

   assign app_wdf_mask = '0;

   // A read may only win while there is room to remember its tag.
   assign elig0  = rq0_valid & (~rq0_cmd | ~full);
   assign elig1  = rq1_valid & (~rq1_cmd | ~full);
   assign win    = (elig0 & elig1) ? ptr : elig1;
   assign gnt    = (state == S_ARB) & init_calib_complete
                 & (elig0 | elig1);
   assign rq0_ready = gnt & (win == 1'b0);
   assign rq1_ready = gnt & (win == 1'b1);
   assign win_rd = win ? rq1_cmd : rq0_cmd;

   assign cmd_ok = app_en & app_rdy;
   assign dat_ok = app_wdf_wren & app_wdf_rdy;
   assign c_nxt  = cmd_done | cmd_ok;
   assign d_nxt  = dat_done | dat_ok;
   assign push   = cmd_ok & (app_cmd == CMD_READ);
   assign pop    = app_rd_data_valid & ~empty;

   always_ff @(posedge ui_clk or posedge ui_clk_sync_rst) begin
      if (ui_clk_sync_rst) begin
         state        <= S_CALIB;
         ptr          <= 1'b0;
         cur_port     <= 1'b0;
         cmd_done     <= 1'b0;
         dat_done     <= 1'b0;
         app_en       <= 1'b0;
         app_cmd      <= CMD_WRITE;
         app_addr     <= '0;
         app_wdf_data <= '0;
         app_wdf_wren <= 1'b0;
         app_wdf_end  <= 1'b0;
      end else begin
         unique case (state)
            S_CALIB: begin
               if (init_calib_complete) state <= S_ARB;
            end
            S_ARB: begin
               if (!init_calib_complete) begin
                  state <= S_CALIB;
               end else if (gnt) begin
                  app_cmd      <= win_rd ? CMD_READ : CMD_WRITE;
                  app_addr     <= win ? rq1_addr : rq0_addr;
                  app_wdf_data <= win ? rq1_wdata : rq0_wdata;
                  ptr          <= ~win;
                  cur_port     <= win;
                  app_en       <= 1'b1;
                  app_wdf_wren <= ~win_rd;
                  app_wdf_end  <= ~win_rd;
                  cmd_done     <= 1'b0;
                  dat_done     <= win_rd;
                  state        <= S_CMD;
               end
            end
            S_CMD: begin
               // Command and data handshakes complete independently.
               if (cmd_ok) app_en <= 1'b0;
               if (dat_ok) begin
                  app_wdf_wren <= 1'b0;
                  app_wdf_end  <= 1'b0;
               end
               cmd_done <= c_nxt;
               dat_done <= d_nxt;
               if (c_nxt && d_nxt) state <= S_ARB;
            end
            default: state <= S_CALIB;
         endcase
      end
   end

   always_ff @(posedge ui_clk or posedge ui_clk_sync_rst) begin
      if (ui_clk_sync_rst) begin
         rd0_valid <= 1'b0;
         rd1_valid <= 1'b0;
         rd0_data  <= '0;
         rd1_data  <= '0;
         tag_err   <= 1'b0;
      end else begin
         rd0_valid <= 1'b0;
         rd1_valid <= 1'b0;
         if (app_rd_data_valid) begin
            if (empty) begin
               tag_err <= 1'b1;
            end else if (tag_head == 1'b0) begin
               rd0_valid <= 1'b1;
               rd0_data  <= app_rd_data;
            end else begin
               rd1_valid <= 1'b1;
               rd1_data  <= app_rd_data;
            end
         end
      end
   end

   mig_tag_fifo #(
      .DEPTH (TAG_DEPTH)
   ) u_tag_fifo (
      .clk   (ui_clk),
      .rst   (ui_clk_sync_rst),
      .push  (push),
      .pop   (pop),
      .din   (cur_port),
      .dout  (tag_head),
      .full  (full),
      .empty (empty)
   );

endmodule

// File: tb/tb_mig_app_arbiter.sv
// Directed bench for mig_app_arbiter: calibration gating, handshakes,
// round-robin order, read routing, tag-full stall, error and reset.
module tb_mig_app_arbiter;

   localparam int AW = 29;
   localparam int DW = 256;
   localparam int TD = 16;

   logic          ui_clk = 1'b0;
   logic          ui_clk_sync_rst = 1'b1;
   logic          init_calib_complete = 1'b0;
   logic          rq0_valid = 1'b0;
   logic          rq0_cmd = 1'b0;
   logic [AW-1:0] rq0_addr = '0;
   logic [DW-1:0] rq0_wdata = '0;
   logic          rq0_ready;
   logic          rq1_valid = 1'b0;
   logic          rq1_cmd = 1'b0;
   logic [AW-1:0] rq1_addr = '0;
   logic [DW-1:0] rq1_wdata = '0;
   logic          rq1_ready;
   logic [DW-1:0] rd0_data;
   logic          rd0_valid;
   logic [DW-1:0] rd1_data;
   logic          rd1_valid;
   logic          app_en;
   logic [2:0]    app_cmd;
   logic [AW-1:0] app_addr;
   logic [DW-1:0] app_wdf_data;
   logic          app_wdf_wren;
   logic          app_wdf_end;
   logic [DW/8-1:0] app_wdf_mask;
   logic          app_rdy = 1'b0;
   logic          app_wdf_rdy = 1'b0;
   logic [DW-1:0] app_rd_data = '0;
   logic          app_rd_data_valid = 1'b0;
   logic          tag_err;

   int total = 0;
   int bad = 0;

   localparam logic [DW-1:0] D1 = {8{32'hD1D1_0001}};
   localparam logic [DW-1:0] D2 = {8{32'hD2D2_0002}};
   localparam logic [DW-1:0] D3 = {8{32'hD3D3_0003}};
   localparam logic [DW-1:0] D4 = {8{32'hD4D4_0004}};

   always #5 ui_clk = ~ui_clk;

   mig_app_arbiter #(
      .ADDR_W    (AW),
      .DATA_W    (DW),
      .TAG_DEPTH (TD)
   ) dut (
      .ui_clk              (ui_clk),
      .ui_clk_sync_rst     (ui_clk_sync_rst),
      .init_calib_complete (init_calib_complete),
      .rq0_valid           (rq0_valid),
      .rq0_cmd             (rq0_cmd),
      .rq0_addr            (rq0_addr),
      .rq0_wdata           (rq0_wdata),
      .rq0_ready           (rq0_ready),
      .rq1_valid           (rq1_valid),
      .rq1_cmd             (rq1_cmd),
      .rq1_addr            (rq1_addr),
      .rq1_wdata           (rq1_wdata),
      .rq1_ready           (rq1_ready),
      .rd0_data            (rd0_data),
      .rd0_valid           (rd0_valid),
      .rd1_data            (rd1_data),
      .rd1_valid           (rd1_valid),
      .app_en              (app_en),
      .app_cmd             (app_cmd),
      .app_addr            (app_addr),
      .app_wdf_data        (app_wdf_data),
      .app_wdf_wren        (app_wdf_wren),
      .app_wdf_end         (app_wdf_end),
      .app_wdf_mask        (app_wdf_mask),
      .app_rdy             (app_rdy),
      .app_wdf_rdy         (app_wdf_rdy),
      .app_rd_data         (app_rd_data),
      .app_rd_data_valid   (app_rd_data_valid),
      .tag_err             (tag_err)
   );

   task automatic do_reset;
      @(negedge ui_clk);
      ui_clk_sync_rst = 1'b1;
      rq0_valid = 1'b0;
      rq1_valid = 1'b0;
      app_rdy = 1'b0;
      app_wdf_rdy = 1'b0;
      app_rd_data_valid = 1'b0;
      repeat (2) @(negedge ui_clk);
      ui_clk_sync_rst = 1'b0;
      init_calib_complete = 1'b1;
      @(negedge ui_clk);
   endtask

   task automatic issue(input int p, input logic c,
                        input logic [AW-1:0] a,
                        input logic [DW-1:0] d);
      bit got;
      got = 1'b0;
      @(negedge ui_clk);
      if (p == 0) begin
         rq0_valid = 1'b1; rq0_cmd = c; rq0_addr = a; rq0_wdata = d;
      end else begin
         rq1_valid = 1'b1; rq1_cmd = c; rq1_addr = a; rq1_wdata = d;
      end
      for (int i = 0; i < 30 && !got; i++) begin
         #1;
         if ((p == 0 && rq0_ready) || (p == 1 && rq1_ready)) got = 1'b1;
         else @(negedge ui_clk);
      end
      total++;
      if (!got) begin
         bad++;
         $display("FAIL issue_grant port=%0d got=0 want=1", p);
      end
      @(negedge ui_clk);
      if (p == 0) rq0_valid = 1'b0;
      else rq1_valid = 1'b0;
      #1;
   endtask

   task automatic test_reset_calib;
      bit seen;
      @(negedge ui_clk);
      rq0_valid = 1'b1; rq0_cmd = 1'b0;
      rq0_addr = AW'(8); rq0_wdata = DW'(2);
      #1;
      total++;
      if ({app_en, app_wdf_wren, app_wdf_end, tag_err,
           rd0_valid, rd1_valid, rq0_ready, rq1_ready} !== 8'h00) begin
         bad++;
         $display("FAIL reset_outputs got=%b want=0", {app_en,
                  app_wdf_wren, app_wdf_end, tag_err, rd0_valid,
                  rd1_valid, rq0_ready, rq1_ready});
      end
      total++;
      if (app_addr !== '0) begin
         bad++;
         $display("FAIL reset_addr got=%h want=0", app_addr);
      end
      @(negedge ui_clk);
      ui_clk_sync_rst = 1'b0;
      seen = 1'b0;
      repeat (50) begin
         @(negedge ui_clk); #1;
         if (rq0_ready || app_en) seen = 1'b1;
      end
      total++;
      if (seen !== 1'b0) begin
         bad++;
         $display("FAIL calib_hold got=%b want=0", seen);
      end
      @(negedge ui_clk);
      init_calib_complete = 1'b1;
      #1;
      total++;
      if (rq0_ready !== 1'b0) begin
         bad++;
         $display("FAIL calib_still_idle got=%b want=0", rq0_ready);
      end
      @(negedge ui_clk); #1;
      total++;
      if (rq0_ready !== 1'b1) begin
         bad++;
         $display("FAIL calib_first_grant got=%b want=1", rq0_ready);
      end
   endtask

   task automatic test_write;
      @(negedge ui_clk);
      rq0_valid = 1'b0;
      #1;
      total++;
      if ({app_en, app_cmd, app_addr, app_wdf_wren, app_wdf_end}
          !== {1'b1, 3'b000, AW'(8), 1'b1, 1'b1}) begin
         bad++;
         $display("FAIL wr_cmd en=%b cmd=%b addr=%h wren=%b end=%b want 1 000 8 1 1",
                  app_en, app_cmd, app_addr, app_wdf_wren, app_wdf_end);
      end
      total++;
      if (app_wdf_data !== DW'(2)) begin
         bad++;
         $display("FAIL wr_data got=%h want=2", app_wdf_data);
      end
      app_rdy = 1'b1;
      @(negedge ui_clk);
      app_rdy = 1'b0;
      rq0_valid = 1'b1; rq0_addr = AW'(16); rq0_wdata = DW'(3);
      #1;
      total++;
      if ({app_en, app_wdf_wren, rq0_ready} !== 3'b010) begin
         bad++;
         $display("FAIL wr_cmd_acc en/wren/rdy got=%b want=010",
                  {app_en, app_wdf_wren, rq0_ready});
      end
      @(negedge ui_clk); #1;
      total++;
      if ({app_en, app_wdf_wren, rq0_ready} !== 3'b010) begin
         bad++;
         $display("FAIL wr_wait1 en/wren/rdy got=%b want=010",
                  {app_en, app_wdf_wren, rq0_ready});
      end
      @(negedge ui_clk);
      app_wdf_rdy = 1'b1;
      #1;
      total++;
      if ({app_wdf_wren, rq0_ready} !== 2'b10) begin
         bad++;
         $display("FAIL wr_wait2 wren/rdy got=%b want=10",
                  {app_wdf_wren, rq0_ready});
      end
      @(negedge ui_clk);
      app_wdf_rdy = 1'b0;
      #1;
      total++;
      if ({app_wdf_wren, app_wdf_end, rq0_ready} !== 3'b001) begin
         bad++;
         $display("FAIL wr_done wren/end/rdy got=%b want=001",
                  {app_wdf_wren, app_wdf_end, rq0_ready});
      end
      @(negedge ui_clk);
      rq0_valid = 1'b0;
      #1;
      total++;
      if ({app_en, app_wdf_wren, app_addr} !== {1'b1, 1'b1, AW'(16)}) begin
         bad++;
         $display("FAIL wr2_cmd en=%b wren=%b addr=%h want 1 1 10",
                  app_en, app_wdf_wren, app_addr);
      end
      app_rdy = 1'b1;
      app_wdf_rdy = 1'b1;
      @(negedge ui_clk);
      app_rdy = 1'b0;
      app_wdf_rdy = 1'b0;
      rq1_valid = 1'b1; rq1_cmd = 1'b0; rq1_addr = AW'(32);
      #1;
      total++;
      if ({app_en, app_wdf_wren, rq1_ready} !== 3'b001) begin
         bad++;
         $display("FAIL wr2_same_cycle en/wren/rdy1 got=%b want=001",
                  {app_en, app_wdf_wren, rq1_ready});
      end
   endtask

   task automatic test_round_robin;
      int cnt0, cnt1, gi, lastp, p;
      bit chk;
      logic [AW-1:0] exp_addr;
      cnt0 = 0; cnt1 = 0; gi = 0; lastp = -1; chk = 1'b0;
      exp_addr = '0;
      do_reset;
      app_rdy = 1'b1;
      app_wdf_rdy = 1'b1;
      rq0_valid = 1'b1; rq0_cmd = 1'b0; rq0_addr = AW'(256);
      rq1_valid = 1'b1; rq1_cmd = 1'b0; rq1_addr = AW'(512);
      for (int i = 0; i < 40; i++) begin
         if (i > 0) begin
            @(negedge ui_clk);
            if (lastp == 0) begin
               if (cnt0 == 4) rq0_valid = 1'b0;
               else rq0_addr = AW'(256 + cnt0);
            end else if (lastp == 1) begin
               if (cnt1 == 4) rq1_valid = 1'b0;
               else rq1_addr = AW'(512 + cnt1);
            end
            lastp = -1;
         end
         #1;
         if (chk) begin
            total++;
            if (app_addr !== exp_addr) begin
               bad++;
               $display("FAIL rr_addr idx=%0d got=%h want=%h",
                        gi - 1, app_addr, exp_addr);
            end
            chk = 1'b0;
         end
         if (rq0_ready || rq1_ready) begin
            p = rq1_ready ? 1 : 0;
            total++;
            if ((rq0_ready && rq1_ready) || p != gi % 2) begin
               bad++;
               $display("FAIL rr_grant idx=%0d got r0=%b r1=%b want port %0d",
                        gi, rq0_ready, rq1_ready, gi % 2);
            end
            exp_addr = p == 1 ? rq1_addr : rq0_addr;
            chk = 1'b1;
            if (p == 1) cnt1++;
            else cnt0++;
            lastp = p;
            gi++;
         end
      end
      total++;
      if (gi != 8) begin
         bad++;
         $display("FAIL rr_count got=%0d want=8", gi);
      end
   endtask

   task automatic test_read_routing;
      do_reset;
      app_rdy = 1'b1;
      issue(0, 1'b1, AW'(64), '0);
      total++;
      if ({app_cmd, app_addr} !== {3'b001, AW'(64)}) begin
         bad++;
         $display("FAIL rd_cmd got cmd=%b addr=%h want 001 40",
                  app_cmd, app_addr);
      end
      issue(1, 1'b1, AW'(128), '0);
      issue(0, 1'b1, AW'(192), '0);
      @(negedge ui_clk);
      app_rd_data = D1;
      app_rd_data_valid = 1'b1;
      #1;
      total++;
      if ({rd0_valid, rd1_valid} !== 2'b00) begin
         bad++;
         $display("FAIL rd_latency got=%b want=00", {rd0_valid, rd1_valid});
      end
      @(negedge ui_clk);
      app_rd_data = D2;
      #1;
      total++;
      if ({rd0_valid, rd1_valid} !== 2'b10 || rd0_data !== D1) begin
         bad++;
         $display("FAIL rd_route1 v=%b data=%h want 10 %h",
                  {rd0_valid, rd1_valid}, rd0_data, D1);
      end
      @(negedge ui_clk);
      app_rd_data = D3;
      #1;
      total++;
      if ({rd0_valid, rd1_valid} !== 2'b01 || rd1_data !== D2) begin
         bad++;
         $display("FAIL rd_route2 v=%b data=%h want 01 %h",
                  {rd0_valid, rd1_valid}, rd1_data, D2);
      end
      @(negedge ui_clk);
      app_rd_data_valid = 1'b0;
      #1;
      total++;
      if ({rd0_valid, rd1_valid} !== 2'b10 || rd0_data !== D3) begin
         bad++;
         $display("FAIL rd_route3 v=%b data=%h want 10 %h",
                  {rd0_valid, rd1_valid}, rd0_data, D3);
      end
      @(negedge ui_clk); #1;
      total++;
      if ({rd0_valid, rd1_valid, tag_err} !== 3'b000) begin
         bad++;
         $display("FAIL rd_strobe_end got=%b want=000",
                  {rd0_valid, rd1_valid, tag_err});
      end
   endtask

   task automatic test_tag_full;
      bit seen;
      do_reset;
      app_rdy = 1'b1;
      for (int k = 0; k < TD; k++) issue(k % 2, 1'b1, AW'(k), '0);
      @(negedge ui_clk);
      rq0_valid = 1'b1; rq0_cmd = 1'b1; rq0_addr = AW'(769);
      rq1_valid = 1'b1; rq1_cmd = 1'b1; rq1_addr = AW'(768);
      seen = 1'b0;
      repeat (6) begin
         @(negedge ui_clk); #1;
         if (rq0_ready || rq1_ready) seen = 1'b1;
      end
      total++;
      if (seen !== 1'b0) begin
         bad++;
         $display("FAIL full_stall got=%b want=0", seen);
      end
      @(negedge ui_clk);
      rq0_cmd = 1'b0; rq0_addr = AW'(1024); rq0_wdata = D3;
      app_wdf_rdy = 1'b1;
      #1;
      total++;
      if ({rq0_ready, rq1_ready} !== 2'b10) begin
         bad++;
         $display("FAIL full_write_grant got=%b want=10",
                  {rq0_ready, rq1_ready});
      end
      @(negedge ui_clk);
      rq0_valid = 1'b0;
      #1;
      total++;
      if ({app_cmd, app_addr} !== {3'b000, AW'(1024)}) begin
         bad++;
         $display("FAIL full_write_cmd got cmd=%b addr=%h want 000 400",
                  app_cmd, app_addr);
      end
      @(negedge ui_clk);
      app_rd_data = D4;
      app_rd_data_valid = 1'b1;
      #1;
      total++;
      if (rq1_ready !== 1'b0) begin
         bad++;
         $display("FAIL full_still_stall got=%b want=0", rq1_ready);
      end
      @(negedge ui_clk);
      app_rd_data_valid = 1'b0;
      #1;
      total++;
      if ({rq1_ready, rd0_valid} !== 2'b11 || rd0_data !== D4) begin
         bad++;
         $display("FAIL full_release rdy1/rd0v=%b data=%h want 11 %h",
                  {rq1_ready, rd0_valid}, rd0_data, D4);
      end
      @(negedge ui_clk);
      rq1_valid = 1'b0;
   endtask

   task automatic test_err_reset;
      do_reset;
      @(negedge ui_clk);
      app_rd_data = D1;
      app_rd_data_valid = 1'b1;
      @(negedge ui_clk);
      app_rd_data_valid = 1'b0;
      #1;
      total++;
      if ({tag_err, rd0_valid, rd1_valid} !== 3'b100) begin
         bad++;
         $display("FAIL err_empty got=%b want=100",
                  {tag_err, rd0_valid, rd1_valid});
      end
      issue(0, 1'b0, AW'(1280), D2);
      @(negedge ui_clk); #1;
      total++;
      if ({app_en, app_wdf_wren, tag_err} !== 3'b111) begin
         bad++;
         $display("FAIL err_inflight got=%b want=111",
                  {app_en, app_wdf_wren, tag_err});
      end
      #1;
      ui_clk_sync_rst = 1'b1;
      #1;
      total++;
      if ({app_en, app_wdf_wren, app_wdf_end, tag_err} !== 4'b0000
          || app_addr !== '0) begin
         bad++;
         $display("FAIL mid_reset got=%b addr=%h want=0000 0",
                  {app_en, app_wdf_wren, app_wdf_end, tag_err}, app_addr);
      end
      rq0_valid = 1'b1; rq0_cmd = 1'b0; rq0_addr = AW'(1536);
      @(negedge ui_clk);
      ui_clk_sync_rst = 1'b0;
      #1;
      total++;
      if (rq0_ready !== 1'b0) begin
         bad++;
         $display("FAIL reset_to_calib got=%b want=0", rq0_ready);
      end
      @(negedge ui_clk); #1;
      total++;
      if (rq0_ready !== 1'b1) begin
         bad++;
         $display("FAIL reset_regrant got=%b want=1", rq0_ready);
      end
      @(negedge ui_clk);
      rq0_valid = 1'b0;
   endtask

   initial begin
      test_reset_calib;
      test_write;
      test_round_robin;
      test_read_routing;
      test_tag_full;
      test_err_reset;
      repeat (2) @(negedge ui_clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
